// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared fetch-path definitions. It holds the fetch FSM state
//               encodings, the bit position of the instruction-length flag
//               and the two PC increment sizes.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // The fetch FSM state encodings. 2'd3 is not used.
  typedef enum logic [1:0] {
    ST_VEC    = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // The first halfword of an instruction has this bit set when the
  // instruction is 32 bits long.
  localparam int LONG_BIT = 15;

  // The PC counts in halfwords.
  localparam int PC_INC_SHORT = 1;
  localparam int PC_INC_LONG  = 2;

endpackage
`default_nettype wire

// File: rtl/inst_len_dec.sv
`default_nettype none
// ============================================================================
// Module      : inst_len_dec
// Description : Decodes the length of an instruction from its first
//               halfword.
// Ports       : hw_i   in  16  first (lowest-addressed) instruction halfword
//               long_o out 1   1 = 32-bit instruction, 0 = 16-bit
// Revision    : 1.0 - initial release
// ============================================================================
module inst_len_dec
  import core_pkg::*;
(
  input  logic [15:0] hw_i,
  output logic        long_o
);

  assign long_o = hw_i[LONG_BIT];

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller. It has a halfword-addressed PC
//               and handles 16-bit and 32-bit instructions. It supports
//               stall, halt and redirect, and can optionally load the start
//               PC from a reset vector.
// Macro       : FETCH_CTRL_RSTVEC_EN
//               Defined   : reset enters VEC and loads the start PC from
//                           M[RESET_VEC_ADDR+1:RESET_VEC_ADDR].
//               Undefined : reset enters FETCH with pc = RESET_VEC_ADDR.
// Ports       : clk         in  1       clock; all state updates on rising edge
//               rst         in  1       asynchronous active-high reset
//               mem_addr    out ADDR_W  halfword address to instruction memory
//               mem_data    in  32      {M[mem_addr+1], M[mem_addr]}
//               stall       in  1       decode back-pressure; hold all state
//               halt        in  1       stop fetching until next redirect
//               redirect    in  1       flush and reload PC
//               redirect_pc in  ADDR_W  new PC on redirect
//               ir          out 32      fetched instruction (short zero-ext)
//               ir_valid    out 1       ir holds a valid instruction
//               ir_pc       out ADDR_W  address of the instruction in ir
//               state_o     out 2       current FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import core_pkg::*;
#(
  parameter int                ADDR_W         = 20,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              stall,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [1:0]        state_o
);

`ifdef FETCH_CTRL_RSTVEC_EN
  localparam fetch_state_e RST_STATE = ST_VEC;
`else
  localparam fetch_state_e RST_STATE = ST_FETCH;
`endif

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              w_long;

  inst_len_dec u_len_dec (
    .hw_i   (mem_data[15:0]),
    .long_o (w_long)
  );

  // The memory wraps the upper-halfword address, so a long fetch at the
  // top address gets M[0] as its upper half with no extra logic here.
  assign mem_addr = (state_q == ST_VEC) ? RESET_VEC_ADDR : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      pc_q       <= RESET_VEC_ADDR;
      ir_q       <= 32'h0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    case (state_q)
      ST_VEC: begin
        // This state is a single cycle. Stall, halt and redirect have no
        // effect here.
`ifdef FETCH_CTRL_RSTVEC_EN
        pc_d = mem_data[ADDR_W-1:0];
`endif
        ir_valid_d = 1'b0;
        state_d    = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          ir_valid_d = 1'b0;
        end else if (stall) begin
          // Hold all state.
        end else if (halt) begin
          ir_valid_d = 1'b0;
          state_d    = ST_HALTED;
        end else begin
          ir_d       = w_long ? mem_data : {16'h0, mem_data[15:0]};
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + (w_long ? ADDR_W'(PC_INC_LONG)
                                      : ADDR_W'(PC_INC_SHORT));
        end
      end

      ST_HALTED: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          ir_valid_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end

      default: begin
        // The unused encoding recovers to FETCH.
        ir_valid_d = 1'b0;
        state_d    = ST_FETCH;
      end
    endcase
  end

  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign ir_pc    = ir_pc_q;
  assign state_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. It runs directed
//               scenarios and then randomized stall/halt/redirect/reset
//               traffic, and compares every cycle against a behavioural
//               model that reads the bench's own memory image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam int          AW = 20;
  localparam logic [19:0] RV = 20'h00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] mem_addr;
  logic [31:0] mem_data;
  logic        stall, halt, redirect;
  logic [19:0] redirect_pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic [19:0] ir_pc;
  logic [1:0]  state_o;

  logic [15:0] mem [0:(1<<20)-1];
  logic [19:0] w_addr_hi;

  int checks   = 0;
  int failures = 0;

  // Model state: 0 = vector load, 1 = fetching, 2 = halted.
  int          m_st;
  logic [19:0] m_pc;
  logic [31:0] m_ir;
  logic [19:0] m_irpc;
  logic        m_valid;

  always #5 clk = ~clk;

  assign w_addr_hi = mem_addr + 20'd1;
  assign mem_data  = {mem[w_addr_hi], mem[mem_addr]};

  fetch_ctrl #(
    .ADDR_W         (AW),
    .RESET_VEC_ADDR (RV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .stall       (stall),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_pc       (ir_pc),
    .state_o     (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
`ifdef FETCH_CTRL_RSTVEC_EN
    m_st = 0;
`else
    m_st = 1;
`endif
    m_pc    = RV;
    m_ir    = 32'h0;
    m_irpc  = 20'h0;
    m_valid = 1'b0;
  endtask

  task automatic check_all();
    check("state", 32'(state_o), 32'(m_st));
    check("mem_addr", 32'(mem_addr), 32'((m_st == 0) ? RV : m_pc));
    check("ir_valid", 32'(ir_valid), 32'(m_valid));
    if (m_valid) begin
      check("ir", ir, m_ir);
      check("ir_pc", 32'(ir_pc), 32'(m_irpc));
    end
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, and
  // compare after the clock edge.
  task automatic step(input bit s, input bit h, input bit r, input logic [19:0] rpc);
    logic [19:0] a1;
    logic [15:0] hw0, hw1;
    int          n_st;
    logic [19:0] n_pc, n_irpc;
    logic [31:0] n_ir;
    logic        n_valid;
    stall = s; halt = h; redirect = r; redirect_pc = rpc;
    n_st = m_st; n_pc = m_pc; n_ir = m_ir; n_irpc = m_irpc; n_valid = m_valid;
    if (m_st == 0) begin
      a1      = RV + 20'd1;
      n_pc    = {mem[a1][3:0], mem[RV]};
      n_valid = 1'b0;
      n_st    = 1;
    end else if (r) begin
      n_pc    = rpc;
      n_valid = 1'b0;
      n_st    = 1;
    end else if (s || m_st == 2) begin
      // nothing changes
    end else if (h) begin
      n_st    = 2;
      n_valid = 1'b0;
    end else begin
      a1      = m_pc + 20'd1;
      hw0     = mem[m_pc];
      hw1     = mem[a1];
      n_irpc  = m_pc;
      n_valid = 1'b1;
      if (hw0 >= 16'h8000) begin
        n_ir = {hw1, hw0};
        n_pc = m_pc + 20'd2;
      end else begin
        n_ir = {16'h0, hw0};
        n_pc = m_pc + 20'd1;
      end
    end
    @(posedge clk);
    #1;
    m_st = n_st; m_pc = n_pc; m_ir = n_ir; m_irpc = n_irpc; m_valid = n_valid;
    check_all();
  endtask

  task automatic reset_checks();
    check("rst_ir_valid", 32'(ir_valid), 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_pc", 32'(ir_pc), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'(RV));
`ifdef FETCH_CTRL_RSTVEC_EN
    check("rst_state", 32'(state_o), 32'd0);
`else
    check("rst_state", 32'(state_o), 32'd1);
`endif
  endtask

  // Assert reset asynchronously mid-cycle, check it took effect at once,
  // then release it away from any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    reset_checks();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    for (int i = 0; i < (1 << 20); i++) mem[i] = 16'($urandom);
    mem[20'h00000] = 16'h0100;
    mem[20'h00001] = 16'h0000;
    mem[20'h00100] = 16'h1234;
    mem[20'h00101] = 16'h8001;
    mem[20'h00102] = 16'hABCD;
    model_reset();

    @(posedge clk);
    @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b0;

`ifdef FETCH_CTRL_RSTVEC_EN
    // Vector load: pc comes from M[1:0] = 0x00000100.
    step(0, 0, 0, 20'h0);
    check("vec_state", 32'(state_o), 32'd1);
    check("vec_mem_addr", 32'(mem_addr), 32'h00100);
    step(0, 0, 0, 20'h0);
    check("first_valid", 32'(ir_valid), 32'h1);
`else
    step(0, 0, 0, 20'h0);
    check("first_valid", 32'(ir_valid), 32'h1);
    check("first_ir", ir, 32'h00000100);
`endif

    // Short then long instruction.
    step(0, 0, 1, 20'h00100);
    check("redir_valid", 32'(ir_valid), 32'h0);
    step(0, 0, 0, 20'h0);
    check("short_ir", ir, 32'h00001234);
    check("short_pc", 32'(ir_pc), 32'h00100);
    step(0, 0, 0, 20'h0);
    check("long_ir", ir, 32'hABCD8001);
    check("long_pc", 32'(ir_pc), 32'h00101);
    check("long_next", 32'(mem_addr), 32'h00103);

    // Three stalled cycles, then resume with no skipped instruction.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 20'h0);
      check("stall_mem_addr", 32'(mem_addr), 32'h00103);
      check("stall_ir_pc", 32'(ir_pc), 32'h00101);
    end
    step(0, 0, 0, 20'h0);
    check("resume_pc", 32'(ir_pc), 32'h00103);

    // Redirect takes priority over stall.
    step(1, 0, 1, 20'h02000);
    check("rs_valid", 32'(ir_valid), 32'h0);
    check("rs_mem_addr", 32'(mem_addr), 32'h02000);
    step(0, 0, 0, 20'h0);
    check("rs_ir_pc", 32'(ir_pc), 32'h02000);

    // Halt at 0x300, stay halted for 10 cycles, then redirect to 0x400.
    step(0, 0, 1, 20'h00300);
    step(0, 1, 0, 20'h0);
    check("halt_state", 32'(state_o), 32'd2);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 20'h0);
      check("halted_valid", 32'(ir_valid), 32'h0);
    end
    step(0, 0, 1, 20'h00400);
    check("unhalt_state", 32'(state_o), 32'd1);
    step(0, 0, 0, 20'h0);
    check("unhalt_ir_pc", 32'(ir_pc), 32'h00400);

    // PC wrap at the top of the address space, short and long.
    mem[20'hFFFFF] = 16'h0042;
    step(0, 0, 1, 20'hFFFFF);
    step(0, 0, 0, 20'h0);
    check("wrap_short_next", 32'(mem_addr), 32'h0);
    check("wrap_short_ir", ir, 32'h00000042);
    mem[20'hFFFFF] = 16'h8042;
    step(0, 0, 1, 20'hFFFFF);
    step(0, 0, 0, 20'h0);
    check("wrap_long_ir", ir, 32'h01008042);
    check("wrap_long_next", 32'(mem_addr), 32'h00001);

    // Reset in the middle of the stream.
    step(0, 0, 0, 20'h0);
    do_reset();
    step(0, 0, 0, 20'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit          s, h, r;
      logic [19:0] rpc;
      s = ($urandom_range(0, 99) < 20);
      h = ($urandom_range(0, 99) < 5);
      r = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 1) == 0) rpc = 20'hFFFF0 + 20'($urandom_range(0, 15));
      else                           rpc = 20'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      step(s, h, r, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
